// File: rtl/count_pwm_gen.sv
// count_pwm_gen: turns a free-running up-count into a registered PWM waveform.
//
// One PWM period spans one full cycle of the upstream counter. The duty
// value (high-time in counts) arrives over a valid/ready handshake. It is
// parked in a single-entry pending register and only becomes the active
// duty at a counter wrap, so a period is never cut short or glitched.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   en            run enable; low forces the idle state
//   q_in          upstream count, +1 per cycle, wraps to 0
//   duty_in       requested high-time in counts
//   duty_valid    duty_in is valid
//   duty_ready    pending slot is free (derived from a register only)
//   pwm_out       registered PWM output
//   period_start  one-cycle pulse on the cycle after a wrap while running
//   running       high while in the run state
//
// Build option:
//   COUNT_PWM_INVERT_EN  when defined, pwm_out is inverted in every state
//                        (idle/reset level 1, low while q_in < duty).

module count_pwm_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic             running
);

  // Level driven on pwm_out whenever the waveform is "off".
`ifdef COUNT_PWM_INVERT_EN
  localparam logic PwmIdle = 1'b1;
`else
  localparam logic PwmIdle = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q_q;
  logic [WIDTH-1:0] active_duty_q, active_duty_d;
  logic [WIDTH-1:0] pending_duty_q, pending_duty_d;
  logic             pending_valid_q, pending_valid_d;
  logic             pwm_q, pwm_d;
  logic             period_start_q, period_start_d;

  logic             wrap;
  logic             transfer;
  logic             apply;
  logic [WIDTH-1:0] next_duty;
  logic             pwm_level;

  // A drop in the count is a wrap; an upstream reset mid-count looks the
  // same and is deliberately treated as one.
  assign wrap       = (q_in < prev_q_q);

  // Ready depends only on registered state, never on duty_valid.
  assign duty_ready = ~pending_valid_q;
  assign transfer   = duty_valid & duty_ready;
  assign apply      = wrap & pending_valid_q;

  // Duty in force for the sample taken on this edge: a pending value that
  // applies on this wrap already governs the first count of the new period.
  assign next_duty  = apply ? pending_duty_q : active_duty_q;

  // Duty registers: apply and transfer are mutually exclusive because a
  // transfer needs an empty pending slot and an apply needs a full one.
  always_comb begin
    active_duty_d   = active_duty_q;
    pending_duty_d  = pending_duty_q;
    pending_valid_d = pending_valid_q;
    if (apply) begin
      active_duty_d   = pending_duty_q;
      pending_valid_d = 1'b0;
    end
    if (transfer) begin
      pending_duty_d  = duty_in;
      pending_valid_d = 1'b1;
    end
  end

  // Control: next state, PWM level and period strobe.
  always_comb begin
    state_d        = state_q;
    pwm_level      = 1'b0;
    period_start_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (!en) begin
          state_d = StIdle;
        end else if (wrap) begin
          // The wrap edge that starts RUN already samples count 0, so the
          // first period is a full one and lines up with period_start.
          state_d        = StRun;
          pwm_level      = (q_in < next_duty);
          period_start_d = 1'b1;
        end
      end
      StRun: begin
        period_start_d = wrap;
        if (!en) begin
          // Disable wins over a coincident wrap; the duty apply still happens.
          state_d = StIdle;
        end else begin
          pwm_level = (q_in < next_duty);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    pwm_d = pwm_level ^ PwmIdle;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      prev_q_q        <= '0;
      active_duty_q   <= '0;
      pending_duty_q  <= '0;
      pending_valid_q <= 1'b0;
      pwm_q           <= PwmIdle;
      period_start_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      prev_q_q        <= q_in;
      active_duty_q   <= active_duty_d;
      pending_duty_q  <= pending_duty_d;
      pending_valid_q <= pending_valid_d;
      pwm_q           <= pwm_d;
      period_start_q  <= period_start_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign running      = (state_q == StRun);

endmodule

// File: tb/tb_count_pwm_gen.sv
// Self-checking bench for count_pwm_gen: directed scenarios plus a random
// phase, all compared cycle by cycle against a behavioural model, with
// extra whole-period high-time counts at the duty boundaries.

module tb_count_pwm_gen;

`ifdef COUNT_PWM_INVERT_EN
  localparam bit Inv = 1'b1;
`else
  localparam bit Inv = 1'b0;
`endif

  localparam int ModeIdle  = 0;
  localparam int ModeArmed = 1;
  localparam int ModeRun   = 2;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] q_in;
  logic [3:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic       period_start;
  logic       running;

  int n_cmp;
  int n_bad;
  int cnt;

  // Behavioural model state.
  int m_mode;
  int m_prev;
  int m_active;
  int m_pend;
  bit m_pend_v;
  bit m_pwm;
  bit m_ps;

  count_pwm_gen #(
    .WIDTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .q_in        (q_in),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = ModeIdle;
    m_prev   = 0;
    m_active = 0;
    m_pend   = 0;
    m_pend_v = 1'b0;
    m_pwm    = 1'b0;
    m_ps     = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs now driven.
  task automatic model_advance();
    int  q;
    bit  wrap;
    bit  take;
    int  duty_now;
    int  mode_nx;
    q        = int'(q_in);
    wrap     = (q < m_prev);
    take     = duty_valid && !m_pend_v;
    duty_now = (wrap && m_pend_v) ? m_pend : m_active;
    mode_nx  = m_mode;
    m_pwm    = 1'b0;
    m_ps     = 1'b0;
    if (m_mode == ModeIdle) begin
      if (en) mode_nx = ModeArmed;
    end else if (m_mode == ModeArmed) begin
      if (!en) mode_nx = ModeIdle;
      else if (wrap) begin
        mode_nx = ModeRun;
        m_pwm   = (q < duty_now);
        m_ps    = 1'b1;
      end
    end else begin
      m_ps = wrap;
      if (!en) mode_nx = ModeIdle;
      else m_pwm = (q < duty_now);
    end
    if (wrap && m_pend_v) begin
      m_active = m_pend;
      m_pend_v = 1'b0;
    end
    if (take) begin
      m_pend   = int'(duty_in);
      m_pend_v = 1'b1;
    end
    m_prev = q;
    m_mode = mode_nx;
  endtask

  task automatic check_model();
    check_eq("pwm_out", int'(pwm_out), int'(m_pwm ^ Inv));
    check_eq("period_start", int'(period_start), int'(m_ps));
    check_eq("running", int'(running), int'(m_mode == ModeRun));
    check_eq("duty_ready", int'(duty_ready), int'(!m_pend_v));
  endtask

  // Called just after a falling edge: drive, step the model, check at the next falling edge.
  task automatic tick(input bit en_v, input bit dv_v, input logic [3:0] d_v);
    en         = en_v;
    duty_valid = dv_v;
    duty_in    = d_v;
    q_in       = 4'(cnt);
    cnt        = (cnt + 1) % 16;
    model_advance();
    @(negedge clk);
    check_model();
  endtask

  // Wait for the next period start, then count high cycles over 16 counts.
  task automatic run_period(input int exp_high, input string tag);
    int highs;
    bit seen;
    seen  = 1'b0;
    highs = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1'b1, 1'b0, 4'd0);
      if (period_start) seen = 1'b1;
    end
    check_eq({tag, " start seen"}, int'(seen), 1);
    if (seen) begin
      highs = int'(pwm_out ^ Inv);
      for (int i = 0; i < 15; i++) begin
        tick(1'b1, 1'b0, 4'd0);
        highs += int'(pwm_out ^ Inv);
      end
      check_eq({tag, " high count"}, highs, exp_high);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    cnt        = 0;
    rst        = 1'b0;
    en         = 1'b0;
    duty_valid = 1'b0;
    duty_in    = 4'd0;
    q_in       = 4'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("reset pwm_out", int'(pwm_out), int'(Inv));
    check_eq("reset period_start", int'(period_start), 0);
    check_eq("reset running", int'(running), 0);
    check_eq("reset duty_ready", int'(duty_ready), 1);
    rst = 1'b1;

    // Enabled, duty never written: output stays off, strobes every wrap.
    cnt = 5;
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 4'd0);
    run_period(0, "no duty");

    // Duty 4 written while idle, then enabled.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 4'd4);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'd0);
    run_period(4, "duty4 first");
    run_period(4, "duty4 second");

    // Update to 10 mid-period at count 6.
    while (cnt != 6) tick(1'b1, 1'b0, 4'd0);
    tick(1'b1, 1'b1, 4'd10);
    check_eq("ready drop after write", int'(duty_ready), 0);
    run_period(10, "duty10");

    // Boundaries.
    tick(1'b1, 1'b1, 4'd0);
    run_period(0, "duty0");
    tick(1'b1, 1'b1, 4'd15);
    run_period(15, "duty15");

    // Disable at count 8, then re-enable.
    while (cnt != 8) tick(1'b1, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 4'd0);
    check_eq("disable pwm off", int'(pwm_out ^ Inv), 0);
    check_eq("disable running", int'(running), 0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 4'd0);
    run_period(15, "resume");

    // Random phase, including upstream discontinuities.
    begin
      bit en_r;
      en_r = 1'b1;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(19, 0) == 0) en_r = ~en_r;
        if ($urandom_range(49, 0) == 0) cnt = 0;
        tick(en_r, ($urandom_range(2, 0) == 0), 4'($urandom_range(15, 0)));
      end
    end

    // Asynchronous reset while the output is high at count 2.
    for (int i = 0; i < 40 && !duty_ready; i++) tick(1'b1, 1'b0, 4'd0);
    tick(1'b1, 1'b1, 4'd4);
    run_period(4, "pre-reset");
    while (cnt != 0) tick(1'b1, 1'b0, 4'd0);
    tick(1'b1, 1'b1, 4'd9);
    tick(1'b1, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 4'd0);
    check_eq("pwm high before reset", int'(pwm_out ^ Inv), 1);
    check_eq("pending before reset", int'(duty_ready), 0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async reset pwm_out", int'(pwm_out), int'(Inv));
    check_eq("async reset duty_ready", int'(duty_ready), 1);
    check_eq("async reset running", int'(running), 0);
    check_eq("async reset period_start", int'(period_start), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 4'd0);
    run_period(0, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case something above stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
